// File: rtl/p2s_shift_16_if.sv
// Load/serial bundle for the p2s_shift_16 parallel-to-serial transmitter.
// A word moves on a rising edge where load_valid && load_ready; load_ready is
// combinational and never depends on load_valid; upstream holds a stable until then.
interface p2s_shift_16_if #(
  parameter int W = 16
);
  logic [W-1:0] a;
  logic         load_valid;
  logic         load_ready;
  logic         en;
  logic         sout;
  logic         sframe;
  logic         done;
  logic         busy_dbg;

  modport master (
    output a, load_valid, en,
    input  load_ready, sout, sframe, done, busy_dbg
  );

  modport slave (
    input  a, load_valid, en,
    output load_ready, sout, sframe, done, busy_dbg
  );
endinterface

// File: rtl/p2s_shift_16.sv
// Parallel-to-serial transmitter: loads a 2**N-bit word by valid/ready and
// shifts it out one bit per enabled clock, chaining words without a gap.
module p2s_shift_16 #(
  parameter int N         = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic           clk,
  input  logic           rst_n,
  p2s_shift_16_if.slave  bus
);
  localparam int             W    = 1 << N;
  localparam logic [N-1:0]   LAST = N'(W - 1);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   shreg_q, shreg_d;
  logic [N-1:0]   cnt_q, cnt_d;
  logic           sout_q, sout_d;
  logic           sframe_q, sframe_d;
  logic           done_q, done_d;

  logic [W-1:0]   ord;
  logic           last_bit;
  logic           load_ready;
  logic           load_fire;

  // Word rearranged into transmission order so the register always shifts left.
  always_comb begin
    ord = '0;
    for (int i = 0; i < W; i++) begin
      ord[i] = MSB_FIRST ? bus.a[i] : bus.a[W-1-i];
    end
  end

  assign last_bit   = (state_q == SHIFT) && bus.en && (cnt_q == LAST);
  assign load_ready = (state_q == IDLE) || last_bit;
  assign load_fire  = bus.load_valid && load_ready;

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    cnt_d    = cnt_q;
    sout_d   = sout_q;
    sframe_d = sframe_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (load_fire) begin
          shreg_d  = {ord[W-2:0], 1'b0};
          cnt_d    = '0;
          sout_d   = ord[W-1];
          sframe_d = 1'b1;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        if (bus.en) begin
          if (cnt_q != LAST) begin
            shreg_d = {shreg_q[W-2:0], 1'b0};
            sout_d  = shreg_q[W-1];
            cnt_d   = cnt_q + N'(1);
          end else begin
            done_d = 1'b1;
            // A load on the last bit chains the next word with no idle cycle.
            if (load_fire) begin
              shreg_d  = {ord[W-2:0], 1'b0};
              cnt_d    = '0;
              sout_d   = ord[W-1];
              sframe_d = 1'b1;
            end else begin
              shreg_d  = '0;
              cnt_d    = '0;
              sout_d   = 1'b0;
              sframe_d = 1'b0;
              state_d  = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      cnt_q    <= '0;
      sout_q   <= 1'b0;
      sframe_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      cnt_q    <= cnt_d;
      sout_q   <= sout_d;
      sframe_q <= sframe_d;
      done_q   <= done_d;
    end
  end

  assign bus.load_ready = load_ready;
  assign bus.sout       = sout_q;
  assign bus.sframe     = sframe_q;
  assign bus.done       = done_q;
  assign bus.busy_dbg   = (state_q == SHIFT);
endmodule
